apb_completer_regfile: RTL and testbench

// - APB completer (slave) end of the apb_if bus: decodes psel_x[SLV_IDX], runs the SETUP/ACCESS handshake
//   and answers with pready, prdata and pslverr.
// - Holds a bank of NUM_REGS word registers: register 0 is a read-only ID, the rest are read/write.
// - Serves as the RTL responder behind the slave agents and as the stand-in DUT for address-filter tests.

---
 rtl/apb_completer_pkg.sv | 9 +
 rtl/apb_completer_decode.sv | 22 ++
 rtl/apb_completer_regfile.sv | 113 +++++++++++
 tb/tb_apb_completer_regfile.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/apb_completer_pkg.sv
// Shared types and constants for the APB completer register file.
package apb_completer_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
   localparam int          WAIT_CNT_W = 4;
   localparam int          IDX_W      = 4;
   localparam int          REG_ID     = 0;
   localparam int          REG_WAIT   = 1;
   localparam logic [31:0] ID_DEFAULT = 32'hA5B0_0001;
endpackage

// File: rtl/apb_completer_decode.sv
// Address decode for the completer: byte address -> register index and error flag.
module apb_completer_decode import apb_completer_pkg::*; #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    NUM_REGS   = 8
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  write,
   output logic [IDX_W-1:0]      idx,
   output logic                  err
);
   logic [ADDR_WIDTH-1:0] off;

   // Range check uses the full shifted offset so far-away addresses never alias.
   always_comb begin
      off = addr - BASE_ADDR;
      idx = IDX_W'(off >> 2);
      err = (addr[1:0] != 2'b00) || (addr < BASE_ADDR) ||
            ((off >> 2) >= ADDR_WIDTH'(NUM_REGS)) ||
            (write && (idx == IDX_W'(REG_ID)));
   end
endmodule

// File: rtl/apb_completer_regfile.sv
// APB completer with an ID register and NUM_REGS-1 RW registers.
// Optional APB_COMPLETER_WAIT_EN: register 1 bits [3:0] set the per-transfer wait states.
module apb_completer_regfile import apb_completer_pkg::*; #(
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    NO_OF_SLAVES = 7,
   parameter int                    SLV_IDX      = 0,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int                    NUM_REGS     = 8,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE     = DATA_WIDTH'(ID_DEFAULT)
) (
   input  logic                           pclock,
   input  logic                           presetn,
   input  logic [NO_OF_SLAVES-1:0]        psel_x,
   input  logic                           penable,
   input  logic                           pwrite,
   input  logic [ADDR_WIDTH-1:0]          paddr,
   input  logic [DATA_WIDTH-1:0]          pwdata,
   output logic [DATA_WIDTH-1:0]          prdata,
   output logic                           pready,
   output logic                           pslverr,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);
   apb_state_e              state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    write_q, write_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   regs_q [1:NUM_REGS-1];
   logic [DATA_WIDTH-1:0]   regs_d [1:NUM_REGS-1];
   logic [IDX_W-1:0]        idx;
   logic                    err, sel, done, psel_unused;
   logic [DATA_WIDTH-1:0]   rdata;

   assign sel         = psel_x[SLV_IDX];
   assign psel_unused = ^psel_x;
   assign done        = (state_q == ACCESS) && (cnt_q == '0);

   apb_completer_decode #(
      .ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR), .NUM_REGS(NUM_REGS)
   ) u_decode (
      .addr(addr_q), .write(write_q), .idx(idx), .err(err)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      regs_d  = regs_q;
      case (state_q)
         IDLE:   if (sel && !penable) state_d = SETUP;
         SETUP: begin
            state_d = ACCESS;
            addr_d  = paddr;
            write_d = pwrite;
            wdata_d = pwdata;
`ifdef APB_COMPLETER_WAIT_EN
            cnt_d   = regs_q[REG_WAIT][WAIT_CNT_W-1:0];
`else
            cnt_d   = '0;
`endif
         end
         ACCESS: begin
            if (cnt_q != '0) begin
               // Abandoned transfer: no write, no response.
               if (!sel) state_d = IDLE;
               else      cnt_d   = cnt_q - 1'b1;
            end else begin
               state_d = (sel && !penable) ? SETUP : IDLE;
               if (write_q && !err)
                  for (int i = 1; i < NUM_REGS; i++)
                     if (idx == IDX_W'(i)) regs_d[i] = wdata_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rdata = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++)
         if (idx == IDX_W'(i)) rdata = regs_q[i];
   end

   assign pready  = done;
   assign pslverr = done && err;
   assign prdata  = (done && !write_q && !err) ? rdata : '0;

   assign reg_q[DATA_WIDTH-1:0] = ID_VALUE;
   for (genvar g = 1; g < NUM_REGS; g++) begin : g_flat
      assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
   end

   always_ff @(posedge pclock or negedge presetn) begin
      if (!presetn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         cnt_q   <= '0;
         for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         regs_q  <= regs_d;
      end
   end
endmodule

// File: tb/tb_apb_completer_regfile.sv
// Directed bench for apb_completer_regfile; honours APB_COMPLETER_WAIT_EN when defined.
module tb_apb_completer_regfile;
   localparam int          DW = 32;
   localparam int          NR = 8;
   localparam logic [31:0] ID = 32'hA5B0_0001;

   logic             pclock = 1'b0;
   logic             presetn;
   logic [6:0]       psel_x;
   logic             penable, pwrite;
   logic [31:0]      paddr, pwdata, prdata;
   logic             pready, pslverr;
   logic [NR*DW-1:0] reg_q;
   int               total = 0;
   int               bad = 0;

   always #5 pclock = ~pclock;

   apb_completer_regfile dut (
      .pclock(pclock), .presetn(presetn), .psel_x(psel_x), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
      .pready(pready), .pslverr(pslverr), .reg_q(reg_q)
   );

   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int waits);
      int guard;
      @(posedge pclock); #1;
      psel_x = 7'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge pclock); #1;
      penable = 1'b1;
      @(posedge pclock); #1;
      waits = 0; guard = 0;
      while (!pready && guard < 40) begin
         waits++; guard++;
         @(posedge pclock); #1;
      end
      if (!pready) begin
         total++; bad++;
         $display("FAIL xfer_timeout addr=%h got pready=0 want 1", a);
      end
      rd = prdata; er = pslverr;
      psel_x = '0; penable = 1'b0;
   endtask

   task automatic test_reset();
      presetn = 1'b0; psel_x = '0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
      repeat (2) @(posedge pclock);
      #1;
      total++; if (pready !== 1'b0) begin bad++; $display("FAIL rst_pready got=%b want=0", pready); end
      total++; if (pslverr !== 1'b0) begin bad++; $display("FAIL rst_pslverr got=%b want=0", pslverr); end
      total++; if (prdata !== 32'h0) begin bad++; $display("FAIL rst_prdata got=%h want=0", prdata); end
      total++; if (reg_q[DW-1:0] !== ID) begin bad++; $display("FAIL rst_id got=%h want=%h", reg_q[DW-1:0], ID); end
      total++; if (reg_q[NR*DW-1:DW] !== '0) begin bad++; $display("FAIL rst_regs got=%h want=0", reg_q[NR*DW-1:DW]); end
      @(negedge pclock); presetn = 1'b1;
   endtask

   task automatic test_id_read();
      logic [31:0] rd; logic er; int w;
      xfer(1'b0, 32'h0, 32'h0, rd, er, w);
      total++; if (rd !== ID) begin bad++; $display("FAIL id_data got=%h want=%h", rd, ID); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL id_err got=%b want=0", er); end
      total++; if (w != 0) begin bad++; $display("FAIL id_latency waits got=%0d want=0", w); end
   endtask

   task automatic test_write_read();
      logic [31:0] rd; logic er; int w;
      xfer(1'b1, 32'h8, 32'hDEAD_BEEF, rd, er, w);
      total++; if (er !== 1'b0) begin bad++; $display("FAIL wr8_err got=%b want=0", er); end
      xfer(1'b0, 32'h8, 32'h0, rd, er, w);
      total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd8_data got=%h want=deadbeef", rd); end
      total++; if (reg_q[2*DW +: DW] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL reg2 got=%h want=deadbeef", reg_q[2*DW +: DW]); end
      xfer(1'b1, 32'h1C, 32'h0123_4567, rd, er, w);
      xfer(1'b0, 32'h1C, 32'h0, rd, er, w);
      total++; if (rd !== 32'h0123_4567 || er !== 1'b0) begin bad++; $display("FAIL rd1c got=%h err=%b want=01234567 err=0", rd, er); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int w;
      xfer(1'b1, 32'h0, 32'hFFFF_FFFF, rd, er, w);
      total++; if (er !== 1'b1) begin bad++; $display("FAIL wr0_err got=%b want=1", er); end
      total++; if (reg_q[DW-1:0] !== ID) begin bad++; $display("FAIL wr0_id got=%h want=%h", reg_q[DW-1:0], ID); end
      xfer(1'b0, 32'h20, 32'h0, rd, er, w);
      total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL rd20 got err=%b data=%h want err=1 data=0", er, rd); end
      xfer(1'b0, 32'h6, 32'h0, rd, er, w);
      total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL rd6 got err=%b data=%h want err=1 data=0", er, rd); end
      xfer(1'b1, 32'h6, 32'h1111_1111, rd, er, w);
      total++; if (er !== 1'b1) begin bad++; $display("FAIL wr6_err got=%b want=1", er); end
      total++; if (reg_q[DW +: DW] !== 32'h0) begin bad++; $display("FAIL wr6_reg1 got=%h want=0", reg_q[DW +: DW]); end
   endtask

   task automatic test_wait();
      logic [31:0] rd; logic er; int w;
      xfer(1'b1, 32'h4, 32'h3, rd, er, w);
      total++; if (w != 0) begin bad++; $display("FAIL wait_wr1 waits got=%0d want=0", w); end
      xfer(1'b0, 32'hC, 32'h0, rd, er, w);
`ifdef APB_COMPLETER_WAIT_EN
      total++; if (w != 3) begin bad++; $display("FAIL wait_rdc waits got=%0d want=3", w); end
`else
      total++; if (w != 0) begin bad++; $display("FAIL wait_rdc waits got=%0d want=0", w); end
`endif
      xfer(1'b0, 32'h4, 32'h0, rd, er, w);
      total++; if (rd !== 32'h3) begin bad++; $display("FAIL rd4 got=%h want=3", rd); end
      xfer(1'b1, 32'h4, 32'h0, rd, er, w);
      xfer(1'b0, 32'hC, 32'h0, rd, er, w);
      total++; if (w != 0) begin bad++; $display("FAIL wait_clr waits got=%0d want=0", w); end
   endtask

   task automatic test_back_to_back();
      @(posedge pclock); #1;
      psel_x = 7'b1; penable = 0; pwrite = 1; paddr = 32'h10; pwdata = 32'hCAFE_F00D;
      @(posedge pclock); #1; penable = 1;
      @(posedge pclock); #1;
      total++; if (pready !== 1'b1) begin bad++; $display("FAIL b2b_wr_ready got=%b want=1", pready); end
      pwrite = 0; penable = 0; paddr = 32'h10;
      @(posedge pclock); #1;
      total++; if (pready !== 1'b0 || reg_q[4*DW +: DW] !== 32'hCAFE_F00D) begin
         bad++; $display("FAIL b2b_setup got ready=%b reg4=%h want ready=0 reg4=cafef00d", pready, reg_q[4*DW +: DW]);
      end
      penable = 1;
      @(posedge pclock); #1;
      total++; if (pready !== 1'b1 || prdata !== 32'hCAFE_F00D || pslverr !== 1'b0) begin
         bad++; $display("FAIL b2b_rd got ready=%b data=%h err=%b want 1 cafef00d 0", pready, prdata, pslverr);
      end
      psel_x = '0; penable = 0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int w;
      @(posedge pclock); #1;
      psel_x = 7'b1; penable = 0; pwrite = 1; paddr = 32'h8; pwdata = 32'h5A5A_5A5A;
      @(posedge pclock); #1; penable = 1;
      @(posedge pclock); #1;
      presetn = 1'b0;
      #1;
      total++; if (pready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b want=0", pready); end
      total++; if (reg_q[2*DW +: DW] !== 32'h0) begin bad++; $display("FAIL midrst_reg2 got=%h want=0", reg_q[2*DW +: DW]); end
      psel_x = '0; penable = 0;
      @(negedge pclock); presetn = 1'b1;
      xfer(1'b0, 32'h8, 32'h0, rd, er, w);
      total++; if (rd !== 32'h0 || er !== 1'b0 || w != 0) begin
         bad++; $display("FAIL midrst_restart got data=%h err=%b waits=%0d want 0 0 0", rd, er, w);
      end
   endtask

   task automatic test_other_sel();
      logic seen;
      seen = 1'b0;
      @(posedge pclock); #1;
      psel_x = 7'b000_1000; penable = 0; pwrite = 0; paddr = 32'h0;
      @(posedge pclock); #1; penable = 1;
      repeat (5) begin
         @(posedge pclock); #1;
         if (pready !== 1'b0) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL other_sel got pready=1 want 0"); end
      psel_x = '0; penable = 0;
   endtask

   initial begin
      test_reset();
      test_id_read();
      test_write_read();
      test_errors();
      test_wait();
      test_back_to_back();
      test_reset_mid();
      test_other_sel();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
